// File: rtl/pipeline_mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Optional ack timeout with a sticky error flag is enabled by defining MEMARB_TIMEOUT_EN.
module pipeline_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              err,
  output logic [1:0]        dbg_state
);

  // Memory handshake: mem_en rises with a registered request and stays high,
  // with mem_we/mem_addr/mem_wdata frozen, until the cycle mem_ack is sampled.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DM_BUSY = 2'd1,
    IF_BUSY = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state, next_state;
  logic              busy;
  logic              finish;
  logic              timeout_hit;
  logic [DATA_W-1:0] cap_data;

  assign busy      = (state == DM_BUSY) || (state == IF_BUSY);
  assign finish    = busy && (mem_ack || timeout_hit);
  assign cap_data  = mem_ack ? mem_rdata : '0;
  assign dbg_state = state;

  // Ready is only high in DONE, so both stalls fall on the advancing edge.
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = (dm_rd | dm_wr) & ~dm_ready;

`ifdef MEMARB_TIMEOUT_EN
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);
  logic [3:0] to_cnt;
  logic       err_q;

  assign timeout_hit = busy && !mem_ack && (to_cnt == TO_LAST);
  assign err         = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (!busy)
        to_cnt <= '0;
      else if (!mem_ack)
        to_cnt <= to_cnt + 4'd1;
      if (timeout_hit)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (dm_rd || dm_wr)
          next_state = DM_BUSY;
        else if (if_req)
          next_state = IF_BUSY;
      end
      DM_BUSY, IF_BUSY: begin
        if (finish)
          next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_rd || dm_wr) begin
            mem_en    <= 1'b1;
            mem_we    <= dm_wr;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (if_req) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end
        end
        DM_BUSY: begin
          if (finish) begin
            mem_en   <= 1'b0;
            dm_ready <= 1'b1;
            if (!mem_we)
              dm_rdata <= cap_data;
          end
        end
        IF_BUSY: begin
          if (finish) begin
            mem_en   <= 1'b0;
            if_ready <= 1'b1;
            if_rdata <= cap_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed bench for pipeline_mem_arbiter: reset, fetch, conflict, store, stray ack, timeout.
module tb_pipeline_mem_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DM   = 2'd1;
  localparam logic [1:0] S_IF   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_rd;
  logic        dm_wr;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        err;
  logic [1:0]  dbg_state;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipeline_mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_rd     (dm_rd),
    .dm_wr     (dm_wr),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .err       (err),
    .dbg_state (dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = '0; dm_rd = 1'b0; dm_wr = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_dm_rdata", dm_rdata, 32'h0);
    check("rst_err", 32'(err), 32'd0);
    #2 reset = 1'b1;

    // 1: reset in the middle of a data access
    tick();
    dm_rd = 1'b1; dm_addr = 32'h30;
    tick();
    check("t1_busy", 32'(dbg_state), 32'(S_DM));
    check("t1_mem_en_busy", 32'(mem_en), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t1_mem_en", 32'(mem_en), 32'd0);
    check("t1_state", 32'(dbg_state), 32'(S_IDLE));
    check("t1_ready", {30'd0, if_ready, dm_ready}, 32'd0);
    check("t1_err", 32'(err), 32'd0);
    dm_rd = 1'b0;
    #2 reset = 1'b1;
    tick();

    // 2: fetch, ack one cycle after mem_en
    if_req = 1'b1; if_addr = 32'h0040_0004;
    #1 check("t2_stall_c0", 32'(stall_if), 32'd1);
    tick();
    check("t2_mem_en_c1", 32'(mem_en), 32'd1);
    check("t2_mem_addr", mem_addr, 32'h0040_0004);
    check("t2_mem_we", 32'(mem_we), 32'd0);
    check("t2_stall_c1", 32'(stall_if), 32'd1);
    tick();
    check("t2_stall_c2", 32'(stall_if), 32'd1);
    check("t2_ready_c2", 32'(if_ready), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("t2_if_ready_c3", 32'(if_ready), 32'd1);
    check("t2_if_rdata", if_rdata, 32'h2008_0005);
    check("t2_stall_c3", 32'(stall_if), 32'd0);
    check("t2_mem_en_c3", 32'(mem_en), 32'd0);
    check("t2_dm_ready_c3", 32'(dm_ready), 32'd0);
    if_req = 1'b0;
    tick();
    check("t2_ready_drop", 32'(if_ready), 32'd0);
    check("t2_idle", 32'(dbg_state), 32'(S_IDLE));

    // 3: simultaneous fetch and load, data first
    if_req = 1'b1; if_addr = 32'h0000_0044; dm_rd = 1'b1; dm_addr = 32'h10;
    tick();
    check("t3_mem_addr_dm", mem_addr, 32'h10);
    check("t3_state_dm", 32'(dbg_state), 32'(S_DM));
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("t3_dm_ready_c2", 32'(dm_ready), 32'd1);
    check("t3_if_ready_c2", 32'(if_ready), 32'd0);
    check("t3_dm_rdata", dm_rdata, 32'h1111_2222);
    check("t3_stall_if_c2", 32'(stall_if), 32'd1);
    check("t3_stall_mem_c2", 32'(stall_mem), 32'd0);
    dm_rd = 1'b0;
    tick();
    check("t3_idle_c3", 32'(dbg_state), 32'(S_IDLE));
    check("t3_dm_ready_c3", 32'(dm_ready), 32'd0);
    tick();
    check("t3_mem_addr_if", mem_addr, 32'h44);
    check("t3_state_if", 32'(dbg_state), 32'(S_IF));
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_C0DE;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("t3_if_ready_c6", 32'(if_ready), 32'd1);
    check("t3_if_rdata", if_rdata, 32'h0BAD_C0DE);
    if_req = 1'b0;
    tick();

    // 4: store with three wait cycles
    dm_wr = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hCAFE_F00D;
    #1 check("t4_stall_c0", 32'(stall_mem), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("t4_mem_we", 32'(mem_we), 32'd1);
      check("t4_mem_wdata", mem_wdata, 32'hCAFE_F00D);
      check("t4_mem_addr", mem_addr, 32'h20);
      check("t4_stall_mem", 32'(stall_mem), 32'd1);
      dm_wdata = 32'h5555_0000 + 32'(c);
      dm_addr  = 32'h100 + 32'(c);
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("t4_dm_ready_c5", 32'(dm_ready), 32'd1);
    check("t4_dm_rdata_kept", dm_rdata, 32'h1111_2222);
    check("t4_mem_en_c5", 32'(mem_en), 32'd0);
    dm_wr = 1'b0;
    tick();

    // 5: stray ack while idle
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("t5_state", 32'(dbg_state), 32'(S_IDLE));
    check("t5_ready", {30'd0, if_ready, dm_ready}, 32'd0);
    check("t5_mem_en", 32'(mem_en), 32'd0);
    tick();
    check("t5_ready_next", {30'd0, if_ready, dm_ready}, 32'd0);

    // 6: fetch with no ack
    if_req = 1'b1; if_addr = 32'h0040_0100;
`ifdef MEMARB_TIMEOUT_EN
    for (int c = 1; c <= 15; c++) begin
      tick();
      check("t6_busy", 32'(dbg_state), 32'(S_IF));
      check("t6_no_ready", 32'(if_ready), 32'd0);
    end
    tick();
    check("t6_to_ready", 32'(if_ready), 32'd1);
    check("t6_to_rdata", if_rdata, 32'h0);
    check("t6_err", 32'(err), 32'd1);
    check("t6_mem_en", 32'(mem_en), 32'd0);
    if_req = 1'b0;
    tick(); tick();
    check("t6_err_sticky", 32'(err), 32'd1);
`else
    for (int c = 1; c <= 100; c++) tick();
    check("t6_stall_c100", 32'(stall_if), 32'd1);
    check("t6_state_c100", 32'(dbg_state), 32'(S_IF));
    check("t6_mem_en_c100", 32'(mem_en), 32'd1);
    check("t6_err", 32'(err), 32'd0);
    if_req = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
